pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage MIPS core: produces D- and E-stage forwarding selects, load-use and branch-compare stalls, and per-stage stall/flush controls. It adds an internal multi-cycle divider stall sequencer, so the E stage no longer needs an external divider busy line. It also adds a precise-exception flush from M. It sits beside the datapath and drives the enable and clear inputs of every pipeline register.

## Interface
- REG_AW, 5: register-address width; 6 covers renamed HI/LO/CP0.
- DIV_CYCLES, 32: total E-stage stall cycles per div/divu; legal range ≥2.
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- rsD, rtD  in  REG_AW  D-stage source registers
- branchD  in  1  D stage holds a compare-in-decode branch
- rsE, rtE, writeregE  in  REG_AW  E-stage sources and destination
- regwriteE  in  1; memtoregE  in  2  (2'b01 = load)
- div_startE  in  1  E stage holds div/divu
- writeregM  in  REG_AW; regwriteM  in  1; memtoregM  in  2
- exceptionM  in  1  exception committed in M this cycle
- writeregW  in  REG_AW; regwriteW  in  1
- forwardaD, forwardbD  out  1  select M result for the branch comparator
- forwardaE, forwardbE  out  2  00 register file, 01 M, 10 W
- stallF, stallD, stallE, stallM, stallW  out  1
- flushF, flushD, flushE, flushM, flushW  out  1
- div_doneE  out  1  divider result valid in E this cycle

## Operation
- Register 0 never matches. For every match rule, REG_AW-bit compare.
- forwardaD = rsD≠0 & rsD==writeregM & regwriteM. forwardbD uses rtD the same way.
- forwardaE = 01 if rsE≠0 & regwriteM & rsE==writeregM. Otherwise 10 if rsE≠0 & regwriteW & rsE==writeregW. Otherwise 00. M has priority over W. forwardbE uses rtE the same way.
- lwstall = memtoregE==01 & rtE≠0 & (rtE==rsD | rtE==rtD).
- brstall = branchD & one of:
  - regwriteE & writeregE≠0 & writeregE ∈ {rsD, rtD}
  - memtoregM==01 & writeregM≠0 & writeregM ∈ {rsD, rtD}
- Divider FSM states: RUN, BUSY, DONE. Down-counter cnt is $clog2(DIV_CYCLES) bits wide.
  - RUN & div_startE & ~exceptionM → BUSY, with cnt ← DIV_CYCLES−2.
  - BUSY: if cnt==0 → DONE, else cnt−1.
  - DONE → RUN unconditionally. While in DONE, div_startE is ignored because the same instruction is still in E.
  - exceptionM in any state → RUN, with cnt ← 0.
- divstall = (RUN & div_startE) | BUSY.
- div_doneE = (state==DONE).
- Output priority:
  1. exceptionM: flushF/D/E/M = 1; all stalls = 0; flushW = 0.
  2. Else divstall: stallF/D/E = 1 and flushM = 1 (bubble into M); flushE = 0.
  3. Else lwstall | brstall: stallF/D = 1 and flushE = 1.
  4. Else all 0.
- stallM, stallW and flushW are always 0. They are reserved ports.

## Timing
- Forwarding, stall and flush outputs are combinational from inputs and state. There are no added cycles.
- div/divu entering E at cycle t: stallE is high for cycles t … t+DIV_CYCLES−1. div_doneE is high at t+DIV_CYCLES with stalls low. The instruction advances to M at the following edge.
- While rst is high: state=RUN, cnt=0, all stall/flush outputs 0, div_doneE 0. Forward outputs remain combinational.
- Reset asserted mid-division aborts it. After release, a div_startE still present restarts the full DIV_CYCLES count.
- exceptionM in the same cycle as div_startE in RUN: flush wins and BUSY is not entered.
- lwstall and divstall together: divstall rules apply and E is not flushed.

## Structure
- Shared package pipe_hazard_pkg holds:
  - enum div_state_t {RUN, BUSY, DONE}
  - FWD_RF=2'b00, FWD_M=2'b01, FWD_W=2'b10
  - MEM_LOAD=2'b01
- Sub-module div_stall_timer (FSM + counter; outputs divstall and div_doneE).
- The top level holds the combinational compare and priority logic.

## Test plan
- add $3 in M, add $3 in W, sub rs=$3 in E → forwardaE=01. Same with rs=$0 → 00.
- lw $5 in E, beq $5,$6 in D → one cycle with stallF=stallD=flushE=1, then forwardaD=1 when lw reaches M.
- div_startE held at DIV_CYCLES=4 → stallE high for exactly 4 cycles and flushM high for the same 4, then div_doneE high for 1 cycle with stallE=0.
- exceptionM on BUSY cycle 2 → flushF/D/E/M=1, stalls=0. Next cycle the state is RUN and div_doneE never pulses.
- rst asserted mid-BUSY, then released with div_startE still high → all outputs 0 during reset, then a fresh DIV_CYCLES-cycle stall.
- lwstall and div_startE in the same cycle → stallE=1, flushE=0, flushM=1.

Source files
------------

// File: rtl/pipe_hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_pkg
//  Brief    : Shared types and encodings for the pipeline hazard controller.
//  Revision : 1.0  initial release
// ============================================================================
package pipe_hazard_pkg;

    // Divider sequencer states
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // E-stage forwarding selects
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b01;
    localparam logic [1:0] FWD_W  = 2'b10;

    // memtoreg encoding of a load
    localparam logic [1:0] MEM_LOAD = 2'b01;

    // True when a memtoreg field marks a load instruction
    function automatic logic is_load(input logic [1:0] memtoreg);
        return (memtoreg == MEM_LOAD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_stall_timer.sv
`default_nettype none
// ============================================================================
//  Module   : div_stall_timer
//  Brief    : Multi-cycle divider stall sequencer. Holds E for DIV_CYCLES
//             cycles per div/divu and then flags the result as valid.
//  Revision : 1.0  initial release
// ============================================================================
import pipe_hazard_pkg::*;

module div_stall_timer #(
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic div_startE,
    input  logic exceptionM,
    output logic divstall,
    output logic div_doneE
);

    localparam int CNT_W = $clog2(DIV_CYCLES);
    // The RUN cycle that sees div_startE is itself the first stall cycle,
    // and the BUSY cycle where cnt reaches zero is the last one.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 2);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; an exception in M aborts any division in flight
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (exceptionM) begin
            state_d = RUN;
            cnt_d   = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (div_startE) begin
                        state_d = BUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    // Same div still sits in E; it leaves at the next edge.
                    state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Stall while a division is being launched or is in progress
    always_comb begin
        divstall  = ((state_q == RUN) && div_startE) || (state_q == BUSY);
        div_doneE = (state_q == DONE);
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Brief    : Hazard controller for the 5-stage MIPS pipeline: forwarding
//             selects, load-use / branch stalls, divider stalls and the
//             precise-exception flush.
//  Revision : 1.0  initial release
// ============================================================================
import pipe_hazard_pkg::*;

module pipe_hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic              branchD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic              regwriteE,
    input  logic [1:0]        memtoregE,
    input  logic              div_startE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic              regwriteM,
    input  logic [1:0]        memtoregM,
    input  logic              exceptionM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteW,
    output logic              forwardaD,
    output logic              forwardbD,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              stallW,
    output logic              flushF,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              flushW,
    output logic              div_doneE
);

    logic w_divstall;
    logic w_lwstall;
    logic w_brstall;
    logic w_br_hitE;
    logic w_br_hitM;

    div_stall_timer #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_timer (
        .clk        (clk),
        .rst        (rst),
        .div_startE (div_startE),
        .exceptionM (exceptionM),
        .divstall   (w_divstall),
        .div_doneE  (div_doneE)
    );

    // Branch comparator forwarding from M; $0 is never a producer
    always_comb begin
        forwardaD = (rsD != '0) && (rsD == writeregM) && regwriteM;
        forwardbD = (rtD != '0) && (rtD == writeregM) && regwriteM;
    end

    // ALU operand forwarding; the younger M result wins over W
    always_comb begin
        forwardaE = FWD_RF;
        forwardbE = FWD_RF;
        if ((rsE != '0) && regwriteM && (rsE == writeregM)) begin
            forwardaE = FWD_M;
        end else if ((rsE != '0) && regwriteW && (rsE == writeregW)) begin
            forwardaE = FWD_W;
        end
        if ((rtE != '0) && regwriteM && (rtE == writeregM)) begin
            forwardbE = FWD_M;
        end else if ((rtE != '0) && regwriteW && (rtE == writeregW)) begin
            forwardbE = FWD_W;
        end
    end

    // Load-use and compare-in-decode branch hazard detection
    always_comb begin
        w_lwstall = is_load(memtoregE) && (rtE != '0) &&
                    ((rtE == rsD) || (rtE == rtD));
        w_br_hitE = regwriteE && (writeregE != '0) &&
                    ((writeregE == rsD) || (writeregE == rtD));
        w_br_hitM = is_load(memtoregM) && (writeregM != '0) &&
                    ((writeregM == rsD) || (writeregM == rtD));
        w_brstall = branchD && (w_br_hitE || w_br_hitM);
    end

    // Stall/flush priority: exception, then divider, then load/branch hazards.
    // Everything is held low while reset is asserted.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        flushF = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        if (!rst) begin
            if (exceptionM) begin
                flushF = 1'b1;
                flushD = 1'b1;
                flushE = 1'b1;
                flushM = 1'b1;
            end else if (w_divstall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                flushM = 1'b1;
            end else if (w_lwstall || w_brstall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

    // Reserved controls: M and W never stall and W is never cleared
    assign stallM = 1'b0;
    assign stallW = 1'b0;
    assign flushW = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Brief    : Self-checking bench for pipe_hazard_ctrl (table vectors,
//             directed multi-cycle sequences, randomized traffic against a
//             behavioural model).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int AW = 5;
    localparam int DC = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic branchD, regwriteE, div_startE, regwriteM, exceptionM, regwriteW;
    logic [1:0] memtoregE, memtoregM;
    logic forwardaD, forwardbD;
    logic [1:0] forwardaE, forwardbE;
    logic stallF, stallD, stallE, stallM, stallW;
    logic flushF, flushD, flushE, flushM, flushW;
    logic div_doneE;

    pipe_hazard_ctrl #(.REG_AW(AW), .DIV_CYCLES(DC)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .branchD(branchD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
        .regwriteE(regwriteE), .memtoregE(memtoregE), .div_startE(div_startE),
        .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
        .exceptionM(exceptionM), .writeregW(writeregW), .regwriteW(regwriteW),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .stallM(stallM), .stallW(stallW),
        .flushF(flushF), .flushD(flushD), .flushE(flushE),
        .flushM(flushM), .flushW(flushW), .div_doneE(div_doneE)
    );

    int errors = 0;
    int checks = 0;

    // Reference divider model: stall cycles still owed after this one,
    // and whether the result is presented this cycle.
    int busy_left = 0;
    bit done_now  = 1'b0;

    logic [16:0] last_outs;

    // Bit map: 16 fwdaD,15 fwdbD,14:13 fwdaE,12:11 fwdbE,10..6 stall F..W,
    // 5..1 flush F..W, 0 div_done
    function automatic logic [16:0] pack_dut();
        return {forwardaD, forwardbD, forwardaE, forwardbE,
                stallF, stallD, stallE, stallM, stallW,
                flushF, flushD, flushE, flushM, flushW, div_doneE};
    endfunction

    function automatic logic [1:0] fwd_e(input logic [AW-1:0] r);
        if (r != 0 && regwriteM && r == writeregM) return 2'b01;
        if (r != 0 && regwriteW && r == writeregW) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [16:0] model();
        bit fad, fbd, lw, br, idle, dv;
        logic [4:0] st, fl;
        fad  = (rsD != 0) && (rsD == writeregM) && regwriteM;
        fbd  = (rtD != 0) && (rtD == writeregM) && regwriteM;
        lw   = (memtoregE == 2'b01) && (rtE != 0) && (rtE == rsD || rtE == rtD);
        br   = branchD &&
               ((regwriteE && writeregE != 0 && (writeregE == rsD || writeregE == rtD)) ||
                (memtoregM == 2'b01 && writeregM != 0 && (writeregM == rsD || writeregM == rtD)));
        idle = (busy_left == 0) && !done_now;
        dv   = (idle && div_startE) || (busy_left > 0);
        st = 5'b0;
        fl = 5'b0;
        if (!rst) begin
            if (exceptionM)     fl = 5'b11110;
            else if (dv)        begin st = 5'b11100; fl = 5'b00010; end
            else if (lw || br)  begin st = 5'b11000; fl = 5'b00100; end
        end
        return {fad, fbd, fwd_e(rsE), fwd_e(rtE), st, fl, done_now && !rst};
    endfunction

    task automatic model_edge();
        if (rst || exceptionM) begin
            busy_left = 0;
            done_now  = 1'b0;
        end else if (done_now) begin
            done_now = 1'b0;
        end else if (busy_left > 0) begin
            busy_left = busy_left - 1;
            if (busy_left == 0) done_now = 1'b1;
        end else if (div_startE) begin
            busy_left = DC - 1;
        end
    endtask

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: compare against the model mid-cycle, then advance the model
    task automatic cycle(input string name);
        @(negedge clk);
        last_outs = pack_dut();
        check(name, last_outs, model());
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        rsD = 0; rtD = 0; branchD = 0; rsE = 0; rtE = 0; writeregE = 0;
        regwriteE = 0; memtoregE = 0; div_startE = 0; writeregM = 0;
        regwriteM = 0; memtoregM = 0; exceptionM = 0; writeregW = 0;
        regwriteW = 0;
    endtask

    function automatic logic [AW-1:0] rnd_reg();
        if ($urandom_range(0, 3) == 0) return AW'($urandom);
        return AW'($urandom_range(0, 7));
    endfunction

    typedef struct {
        logic [AW-1:0] rsD, rtD; logic branchD;
        logic [AW-1:0] rsE, rtE, wrE; logic rwE; logic [1:0] mtrE;
        logic [AW-1:0] wrM; logic rwM; logic [1:0] mtrM; logic exc;
        logic [AW-1:0] wrW; logic rwW;
        logic [1:0] fD; logic [1:0] faE, fbE; logic st; logic flE; logic flX;
    } vec_t;

    vec_t tbl [16];

    int n_se, n_fm, n_done, done_at;

    initial begin
        // rsD rtD br rsE rtE wrE rwE mtrE wrM rwM mtrM exc wrW rwW | fD faE fbE st flE flX
        tbl[0]  = '{0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0,  2'b00, 2'b00, 2'b00, 0, 0, 0};
        tbl[1]  = '{0, 0, 0,  3, 0, 0, 0, 0,  3, 1, 0, 0,  3, 1,  2'b00, 2'b01, 2'b00, 0, 0, 0};
        tbl[2]  = '{0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 0, 0,  0, 1,  2'b00, 2'b00, 2'b00, 0, 0, 0};
        tbl[3]  = '{0, 0, 0,  0, 4, 0, 0, 0,  0, 0, 0, 0,  4, 1,  2'b00, 2'b00, 2'b10, 0, 0, 0};
        tbl[4]  = '{0, 0, 0,  3, 0, 0, 0, 0,  3, 0, 0, 0,  3, 1,  2'b00, 2'b10, 2'b00, 0, 0, 0};
        tbl[5]  = '{5, 0, 0,  0, 5, 5, 1, 1,  0, 0, 0, 0,  0, 0,  2'b00, 2'b00, 2'b00, 1, 1, 0};
        tbl[6]  = '{5, 0, 0,  0, 5, 5, 1, 2,  0, 0, 0, 0,  0, 0,  2'b00, 2'b00, 2'b00, 0, 0, 0};
        tbl[7]  = '{0, 0, 0,  0, 0, 0, 1, 1,  0, 0, 0, 0,  0, 0,  2'b00, 2'b00, 2'b00, 0, 0, 0};
        tbl[8]  = '{6, 2, 1,  0, 0, 6, 1, 0,  0, 0, 0, 0,  0, 0,  2'b00, 2'b00, 2'b00, 1, 1, 0};
        tbl[9]  = '{6, 2, 1,  0, 0, 6, 0, 0,  0, 0, 0, 0,  0, 0,  2'b00, 2'b00, 2'b00, 0, 0, 0};
        tbl[10] = '{1, 7, 1,  0, 0, 0, 0, 0,  7, 1, 1, 0,  0, 0,  2'b01, 2'b00, 2'b00, 1, 1, 0};
        tbl[11] = '{9, 0, 0,  0, 0, 0, 0, 0,  9, 1, 0, 0,  0, 0,  2'b10, 2'b00, 2'b00, 0, 0, 0};
        tbl[12] = '{25,0, 0,  0, 0, 0, 0, 0,  9, 1, 0, 0,  0, 0,  2'b00, 2'b00, 2'b00, 0, 0, 0};
        tbl[13] = '{5, 0, 0,  0, 5, 5, 1, 1,  0, 0, 0, 1,  0, 0,  2'b00, 2'b00, 2'b00, 0, 1, 1};
        tbl[14] = '{0, 0, 0, 17, 1, 0, 0, 0,  1, 1, 0, 0,  0, 0,  2'b00, 2'b00, 2'b01, 0, 0, 0};
        tbl[15] = '{0, 0, 1,  0, 0, 0, 1, 0,  0, 0, 1, 0,  0, 0,  2'b00, 2'b00, 2'b00, 0, 0, 0};

        // ---- reset state ----
        clear_inputs();
        rst = 1'b1;
        div_startE = 1'b1;
        @(negedge clk);
        check("reset_outputs", pack_dut(), 17'h0);
        @(posedge clk); model_edge(); #1;
        div_startE = 1'b0;
        rst = 1'b0;

        // ---- table vectors (divider idle) ----
        foreach (tbl[i]) begin
            rsD = tbl[i].rsD; rtD = tbl[i].rtD; branchD = tbl[i].branchD;
            rsE = tbl[i].rsE; rtE = tbl[i].rtE; writeregE = tbl[i].wrE;
            regwriteE = tbl[i].rwE; memtoregE = tbl[i].mtrE;
            writeregM = tbl[i].wrM; regwriteM = tbl[i].rwM; memtoregM = tbl[i].mtrM;
            exceptionM = tbl[i].exc; writeregW = tbl[i].wrW; regwriteW = tbl[i].rwW;
            div_startE = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d", i), pack_dut(),
                  {tbl[i].fD, tbl[i].faE, tbl[i].fbE,
                   tbl[i].st, tbl[i].st, 3'b000,
                   tbl[i].flX, tbl[i].flX, tbl[i].flE, tbl[i].flX, 1'b0, 1'b0});
            @(posedge clk); model_edge(); #1;
        end

        // ---- lw $5 in E followed by beq $5,$6 in D ----
        clear_inputs();
        memtoregE = 2'b01; rtE = 5; writeregE = 5; regwriteE = 1;
        branchD = 1; rsD = 5; rtD = 6;
        cycle("lw_beq_e");
        check_int("lw_beq_stall", int'(last_outs[10:9] == 2'b11 && last_outs[3]), 1);
        memtoregE = 0; rtE = 0; writeregE = 0; regwriteE = 0;
        writeregM = 5; regwriteM = 1; memtoregM = 2'b01;
        cycle("lw_beq_m");
        check_int("lw_beq_fwdaD", int'(last_outs[16]), 1);

        // ---- divider held for DIV_CYCLES ----
        clear_inputs();
        n_se = 0; n_fm = 0; n_done = 0; done_at = -1;
        div_startE = 1'b1;
        for (int k = 0; k < DC + 4; k++) begin
            if (k == DC + 1) div_startE = 1'b0;
            cycle("div_seq");
            n_se += int'(last_outs[8]);
            n_fm += int'(last_outs[2]);
            if (last_outs[0]) begin
                n_done++;
                done_at = k;
                check_int("div_done_no_stall", int'(last_outs[8]), 0);
            end
        end
        check_int("div_stallE_cycles", n_se, DC);
        check_int("div_flushM_cycles", n_fm, DC);
        check_int("div_done_pulses", n_done, 1);
        check_int("div_done_cycle", done_at, DC);

        // ---- exception on the second BUSY cycle ----
        clear_inputs();
        n_done = 0;
        div_startE = 1'b1;
        cycle("exc_start");
        cycle("exc_busy1");
        exceptionM = 1'b1;
        cycle("exc_busy2");
        check("exc_flush", last_outs[10:1], 10'b00000_11110);
        exceptionM = 1'b0;
        div_startE = 1'b0;
        for (int k = 0; k < DC + 3; k++) begin
            cycle("exc_after");
            n_done += int'(last_outs[0]);
            n_se   += 0;
        end
        check_int("exc_no_done", n_done, 0);

        // ---- reset mid-division, restart with div_startE held ----
        clear_inputs();
        div_startE = 1'b1;
        cycle("rst_start");
        cycle("rst_busy1");
        rst = 1'b1;
        cycle("rst_hold1");
        check("rst_ctrl_zero", last_outs[10:0], 11'h0);
        cycle("rst_hold2");
        rst = 1'b0;
        n_se = 0; n_done = 0; done_at = -1;
        for (int k = 0; k < DC + 1; k++) begin
            cycle("rst_restart");
            n_se += int'(last_outs[8]);
            if (last_outs[0]) begin n_done++; done_at = k; end
        end
        check_int("rst_restart_stall", n_se, DC);
        check_int("rst_restart_done", done_at, DC);
        div_startE = 1'b0;
        cycle("rst_idle");

        // ---- load-use and divider in the same cycle ----
        clear_inputs();
        memtoregE = 2'b01; rtE = 5; rsD = 5; div_startE = 1'b1;
        cycle("lw_div");
        check("lw_div_ctrl", {last_outs[8], last_outs[3], last_outs[2]}, 17'b101);
        for (int k = 0; k < DC; k++) cycle("lw_div_run");
        clear_inputs();
        cycle("lw_div_idle");

        // ---- randomized traffic against the model ----
        for (int k = 0; k < 600; k++) begin
            rsD = rnd_reg(); rtD = rnd_reg(); branchD = 1'($urandom);
            rsE = rnd_reg(); rtE = rnd_reg(); writeregE = rnd_reg();
            regwriteE = 1'($urandom); memtoregE = 2'($urandom);
            writeregM = rnd_reg(); regwriteM = 1'($urandom); memtoregM = 2'($urandom);
            writeregW = rnd_reg(); regwriteW = 1'($urandom);
            exceptionM = ($urandom_range(0, 11) == 0);
            div_startE = ($urandom_range(0, 2) == 0);
            if (rst) rst = ($urandom_range(0, 1) == 0);
            else     rst = ($urandom_range(0, 59) == 0);
            cycle("random");
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time guard so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
